addr_dec_burst: RTL
===================

// Module: addr_dec_burst
// PURPOSE
//  Parametrised bus-slave address decoder with burst support; sits between the serial-slave byte FSM and the peripheral register bank.
//  Frame format: first byte = register address + R/W bit; each following byte is written to, or read from, the selected peripheral.
//  Drives a one-hot chip select per peripheral and NACKs out-of-range addresses.
//  Optional address auto-increment across a burst.
// PARAMETERS
//  NUM_PERIPH  4   number of peripherals; width of cs; legal range 1..2**(ADDR_W-REG_W)
//  ADDR_W      7   register address width; must satisfy ADDR_W <= DATA_W-1
//  REG_W       4   register-offset bits per peripheral; upper ADDR_W-REG_W bits = peripheral index
//  DATA_W      8   byte/data width
// PORTS
//  clk            in   1           system clock, rising edge
//  rst            in   1           asynchronous, active-low reset
//  frame_start    in   1           1-cycle pulse: start / repeated start seen
//  frame_stop     in   1           1-cycle pulse: stop seen
//  d_in           in   DATA_W      received byte
//  data_received  in   1           1-cycle strobe: d_in valid
//  rd_req         in   1           1-cycle strobe: FSM needs next read byte
//  d_out          out  DATA_W      byte to transmit
//  d_out_valid    out  1           1-cycle pulse: d_out updated
//  nack           out  1           address out of range; held until frame end
//  address        out  ADDR_W      current register address
//  w_data         out  DATA_W      write data
//  r_data         in   DATA_W      peripheral read data; valid 1 cycle after rd
//  wr             out  1           1-cycle write strobe
//  rd             out  1           1-cycle read strobe
//  cs             out  NUM_PERIPH  one-hot chip select; held for the whole access phase
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; every output 0.
//  States: IDLE, ADDR, WRITE, READ, RWAIT, ERR.
//  IDLE  -> ADDR on frame_start.
//  ADDR, on data_received:
//   - latch address=d_in[ADDR_W:1], rw=d_in[0] (1=read); idx=address[ADDR_W-1:REG_W].
//   - idx>=NUM_PERIPH -> ERR, nack=1, cs=0.
//   - rw=0 -> WRITE, cs[idx]=1 on the next cycle.
//   - rw=1 -> RWAIT, cs[idx]=1, rd=1 on the next cycle.
//  WRITE, each data_received: next cycle wr=1, w_data=d_in, address unchanged.
//  RWAIT: cycle after rd, capture d_out=r_data, pulse d_out_valid; -> READ.
//  READ, rd_req: next cycle rd=1 -> RWAIT. rd_req during RWAIT is ignored.
//  ERR: data_received and rd_req ignored; no wr/rd; nack held.
//  frame_stop, any state: next cycle -> IDLE; cs, nack, wr, rd = 0; d_out held.
//  frame_start, any non-IDLE state (repeated start): -> ADDR; cs, nack = 0.
//  Priority when coincident: frame_stop > frame_start > data_received/rd_req.
//  data_received in IDLE is ignored.
//  Reset mid-burst: immediate return to reset values; no partial strobe.
// CONFIGURATION
//  ADEC_AUTOINC_EN defined:
//   - after each wr and each rd, offset address[REG_W-1:0] increments by 1.
//   - offset wraps at 2**REG_W-1 -> 0; peripheral index never changes.
//   - first access uses the latched address.
//  ADEC_AUTOINC_EN undefined: address is fixed for the whole frame.
// STRUCTURE
//  Package adec_pkg:
//   - adec_state_e enum.
//   - RW_READ/RW_WRITE constants.
//   - function periph_idx() that extracts the index from an address.
//  Sub-module adec_cs_decode:
//   - combinational index -> one-hot cs, gated by an enable.
//   - range-check output feeds nack.
// TESTING (defaults, autoinc on unless noted)
//  1. start, byte 8'h22 (addr 0x11, W), data 8'hA5, 8'h5A, stop
//     -> wr at 0x11 w_data A5, then wr at 0x12 w_data 5A; cs=4'b0010 throughout; cs=0 after stop.
//  2. start, byte 8'h1F (addr 0x0F, R), r_data=8'h3C, then rd_req
//     -> rd at 0x0F, d_out=3C with d_out_valid; second rd at 0x00 (wrap within peripheral 0).
//  3. start, byte 8'hA0 (addr 0x50, idx 5 >= 4), 2 data bytes
//     -> nack=1, cs=0, no wr; nack clears on stop.
//  4. Write burst, repeated start, byte 8'h41 (read, addr 0x20)
//     -> cs 4'b0001 -> 0 -> 4'b0100; rd asserted.
//  5. data_received and frame_stop in the same cycle in WRITE -> no wr; IDLE.
//     Also: rst low mid-burst -> all outputs 0 immediately.
//  6. Autoinc off: 3-byte write at 0x11 -> all three wr at 0x11.

Source files
------------

// File: rtl/addr_dec_burst_pkg.sv
// Shared types and helpers for the addr_dec_burst address decoder.
package adec_pkg;

  // Frame-level decoder states
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAddr  = 3'd1,
    StWrite = 3'd2,
    StRead  = 3'd3,
    StRwait = 3'd4,
    StErr   = 3'd5
  } adec_state_e;

  // Value of the R/W bit (bit 0 of the address byte)
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Peripheral index = address bits above the register-offset field
  function automatic int unsigned periph_idx(input logic [31:0] addr, input int unsigned reg_w);
    return int'(addr >> reg_w);
  endfunction

endpackage

// File: rtl/addr_dec_burst_cs_decode.sv
// Peripheral index to one-hot chip-select decoder with range check.
module adec_cs_decode #(
  parameter int unsigned NUM_PERIPH = 4,
  parameter int unsigned IDX_W      = 3
) (
  input  logic [IDX_W-1:0]      idx_i,
  input  logic                  en_i,
  output logic [NUM_PERIPH-1:0] cs_o,
  output logic                  in_range_o
);

  // Index must name an existing peripheral; independent of the enable
  assign in_range_o = (32'(idx_i) < NUM_PERIPH);

  // One-hot select, all zero when disabled or out of range
  always_comb begin
    cs_o = '0;
    for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
      cs_o[i] = en_i && (32'(idx_i) == i);
    end
  end

endmodule

// File: rtl/addr_dec_burst.sv
// Bus-slave address decoder with burst support.
// First frame byte carries {address, R/W}; following bytes are written to, or
// read from, the selected peripheral. Out-of-range addresses are NACKed.
// Build option: define ADEC_AUTOINC_EN to auto-increment the register offset
// after every wr/rd strobe (offset wraps, peripheral index is preserved).
module addr_dec_burst
  import adec_pkg::*;
#(
  parameter int unsigned NUM_PERIPH = 4,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned REG_W      = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  frame_stop,
  input  logic [DATA_W-1:0]     d_in,
  input  logic                  data_received,
  input  logic                  rd_req,
  output logic [DATA_W-1:0]     d_out,
  output logic                  d_out_valid,
  output logic                  nack,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W-1:0]     w_data,
  input  logic [DATA_W-1:0]     r_data,
  output logic                  wr,
  output logic                  rd,
  output logic [NUM_PERIPH-1:0] cs
);

  localparam int unsigned IDX_W = ADDR_W - REG_W;

  adec_state_e           state_q, state_d;
  logic [ADDR_W-1:0]     address_q, address_d;
  logic                  cs_en_q, cs_en_d;
  logic [NUM_PERIPH-1:0] cs_q, cs_d;
  logic                  nack_q, nack_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [DATA_W-1:0]     w_data_q, w_data_d;
  logic [DATA_W-1:0]     d_out_q, d_out_d;
  logic                  d_out_valid_q, d_out_valid_d;

  logic [ADDR_W-1:0]     addr_byte;
  logic                  addr_rw;
  logic                  addr_hit;
  logic [IDX_W-1:0]      idx_d;
  logic                  in_range;

  assign addr_byte = d_in[ADDR_W:1];
  assign addr_rw   = d_in[0];
  // Address byte accepted this cycle (stop/start take priority)
  assign addr_hit  = (state_q == StAddr) && data_received && !frame_stop && !frame_start;

  // Next register address: latch from the address byte, optionally step after a strobe
  always_comb begin
    address_d = address_q;
    if (addr_hit) begin
      address_d = addr_byte;
    end
`ifdef ADEC_AUTOINC_EN
    else if (wr_q || rd_q) begin
      address_d[REG_W-1:0] = address_q[REG_W-1:0] + 1'b1;
    end
`endif
  end

  assign idx_d = IDX_W'(periph_idx(32'(address_d), REG_W));

  // Chip select is decoded from the next address so cs changes together with address
  adec_cs_decode #(
    .NUM_PERIPH(NUM_PERIPH),
    .IDX_W     (IDX_W)
  ) u_cs_decode (
    .idx_i     (idx_d),
    .en_i      (cs_en_d),
    .cs_o      (cs_d),
    .in_range_o(in_range)
  );

  // Frame FSM and strobe generation
  always_comb begin
    state_d       = state_q;
    cs_en_d       = cs_en_q;
    nack_d        = nack_q;
    wr_d          = 1'b0;
    rd_d          = 1'b0;
    w_data_d      = w_data_q;
    d_out_d       = d_out_q;
    d_out_valid_d = 1'b0;

    if (frame_stop) begin
      state_d = StIdle;
      cs_en_d = 1'b0;
      nack_d  = 1'b0;
    end else if (frame_start) begin
      state_d = StAddr;
      cs_en_d = 1'b0;
      nack_d  = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (data_received) begin
            if (!in_range) begin
              state_d = StErr;
              nack_d  = 1'b1;
            end else if (addr_rw == RW_READ) begin
              state_d = StRwait;
              cs_en_d = 1'b1;
              rd_d    = 1'b1;
            end else begin
              state_d = StWrite;
              cs_en_d = 1'b1;
            end
          end
        end
        StWrite: begin
          if (data_received) begin
            wr_d     = 1'b1;
            w_data_d = d_in;
          end
        end
        StRead: begin
          if (rd_req) begin
            state_d = StRwait;
            rd_d    = 1'b1;
          end
        end
        StRwait: begin
          // r_data is valid the cycle after the rd strobe
          if (!rd_q) begin
            d_out_d       = r_data;
            d_out_valid_d = 1'b1;
            state_d       = StRead;
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      address_q     <= '0;
      cs_en_q       <= 1'b0;
      cs_q          <= '0;
      nack_q        <= 1'b0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      w_data_q      <= '0;
      d_out_q       <= '0;
      d_out_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      cs_en_q       <= cs_en_d;
      cs_q          <= cs_d;
      nack_q        <= nack_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      w_data_q      <= w_data_d;
      d_out_q       <= d_out_d;
      d_out_valid_q <= d_out_valid_d;
    end
  end

  assign address     = address_q;
  assign cs          = cs_q;
  assign nack        = nack_q;
  assign wr          = wr_q;
  assign rd          = rd_q;
  assign w_data      = w_data_q;
  assign d_out       = d_out_q;
  assign d_out_valid = d_out_valid_q;

endmodule
